// File: rtl/inter_buf_scheduler_if.sv
// Port bundle between the intermediate-buffer scheduler and its surroundings:
// the pooled-result write stream, the consumer read handshake, both buffer
// ports and the consumer input-valid strobes.
interface inter_buf_scheduler_if #(
  parameter int ADDR_W = 10
);
  logic              wr_valid;
  logic [47:0]       wr_data;
  logic              rd_ready;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [47:0]       dina;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic              conv2_i_valid;
  logic              conv2_win_last;
  logic              fc1_i_valid;

  // scheduler side
  modport master (
    input  wr_valid, wr_data, rd_ready,
    output ena, wea, addra, dina, enb, addrb,
           conv2_i_valid, conv2_win_last, fc1_i_valid
  );

  // producer / buffer / consumer side
  modport slave (
    output wr_valid, wr_data, rd_ready,
    input  ena, wea, addra, dina, enb, addrb,
           conv2_i_valid, conv2_win_last, fc1_i_valid
  );
endinterface

// File: rtl/inter_buf_scheduler.sv
// Sequencer for the shared 48-bit intermediate feature-map buffer.
// Writes layer-1 pooled results, streams 5x5 conv2 windows out of them,
// writes layer-2 pooled results, streams those linearly to FC1.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | port controls quiet, waiting for i_start
// S_WR_L1  | capturing layer-1 pooled results on port A
// S_RD_L1  | issuing conv2 sliding-window reads on port B
// S_WR_L2  | capturing layer-2 pooled results on port A
// S_RD_L2  | issuing linear FC1 reads on port B
// S_DONE   | one-cycle completion pulse, then back to idle
module inter_buf_scheduler #(
  parameter int MAP1_W    = 12,
  parameter int MAP1_H    = 12,
  parameter int K         = 5,
  parameter int MAP2_N    = 16,
  parameter int ADDR_STEP = 6,
  parameter int ADDR_W    = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  inter_buf_scheduler_if.master  bus,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int NWR1   = MAP1_W * MAP1_H;
  localparam int NWR2   = MAP2_N;
  localparam int OX_N   = MAP1_W - K + 1;
  localparam int OY_N   = MAP1_H - K + 1;
  localparam int NRD1   = OX_N * OY_N * K * K;
  localparam int NRD2   = MAP2_N;
  localparam int NWR_MX = (NWR1 > NWR2) ? NWR1 : NWR2;
  localparam int NRD_MX = (NRD1 > NRD2) ? NRD1 : NRD2;
  localparam int POS_MX = (OX_N > OY_N) ? OX_N : OY_N;
  localparam int WC_W   = $clog2(NWR_MX + 1);
  localparam int RC_W   = $clog2(NRD_MX + 1);
  localparam int PW     = $clog2(POS_MX + 1);
  localparam int KW     = $clog2(K + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_L1 = 3'd1,
    S_RD_L1 = 3'd2,
    S_WR_L2 = 3'd3,
    S_RD_L2 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  logic [WC_W-1:0]   r_wr_cnt;
  logic [RC_W-1:0]   r_rd_cnt;
  logic [PW-1:0]     r_ox;
  logic [PW-1:0]     r_oy;
  logic [KW-1:0]     r_kr;
  logic [KW-1:0]     r_kc;
  logic              r_ena;
  logic              r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [47:0]       r_dina;
  logic              r_enb;
  logic [ADDR_W-1:0] r_addrb;
  logic              r_iss_conv2;
  logic              r_iss_last;
  logic              r_iss_fc1;
  logic              r_conv2_valid;
  logic              r_conv2_last;
  logic              r_fc1_valid;
  logic              r_done;
  logic              r_err;

  logic              w_in_wr;
  logic              w_wr_last;
  logic              w_rd_last;
  logic              w_win_last;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_rd_addr_l1;
  logic [ADDR_W-1:0] w_rd_addr_l2;

  // Terminal-count compares and the address each counter set points at.
  always_comb begin
    w_in_wr      = (r_state == S_WR_L1) || (r_state == S_WR_L2);
    w_wr_last    = (r_state == S_WR_L1) ? (r_wr_cnt == WC_W'(NWR1 - 1))
                                        : (r_wr_cnt == WC_W'(NWR2 - 1));
    w_rd_last    = (r_state == S_RD_L1) ? (r_rd_cnt == RC_W'(NRD1 - 1))
                                        : (r_rd_cnt == RC_W'(NRD2 - 1));
    w_win_last   = (r_kr == KW'(K - 1)) && (r_kc == KW'(K - 1));
    w_wr_addr    = ADDR_W'(r_wr_cnt) * ADDR_W'(ADDR_STEP);
    w_row        = ADDR_W'(r_oy) + ADDR_W'(r_kr);
    w_col        = ADDR_W'(r_ox) + ADDR_W'(r_kc);
    w_rd_addr_l1 = (w_row * ADDR_W'(MAP1_W) + w_col) * ADDR_W'(ADDR_STEP);
    w_rd_addr_l2 = ADDR_W'(r_rd_cnt) * ADDR_W'(ADDR_STEP);
  end

  // Schedule FSM with all port controls and strobes registered.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_ox          <= '0;
      r_oy          <= '0;
      r_kr          <= '0;
      r_kc          <= '0;
      r_ena         <= 1'b0;
      r_wea         <= 1'b0;
      r_addra       <= '0;
      r_dina        <= '0;
      r_enb         <= 1'b0;
      r_addrb       <= '0;
      r_iss_conv2   <= 1'b0;
      r_iss_last    <= 1'b0;
      r_iss_fc1     <= 1'b0;
      r_conv2_valid <= 1'b0;
      r_conv2_last  <= 1'b0;
      r_fc1_valid   <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_ena         <= 1'b0;
      r_wea         <= 1'b0;
      r_enb         <= 1'b0;
      r_iss_conv2   <= 1'b0;
      r_iss_last    <= 1'b0;
      r_iss_fc1     <= 1'b0;
      r_done        <= 1'b0;
      // consumer strobes trail the read issue by the buffer's read latency
      r_conv2_valid <= r_iss_conv2;
      r_conv2_last  <= r_iss_last;
      r_fc1_valid   <= r_iss_fc1;

      if (bus.wr_valid && !w_in_wr) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_WR_L1;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_kr     <= '0;
            r_kc     <= '0;
          end
        end

        S_WR_L1, S_WR_L2: begin
          if (bus.wr_valid) begin
            r_ena   <= 1'b1;
            r_wea   <= 1'b1;
            r_dina  <= bus.wr_data;
            r_addra <= w_wr_addr;
            if (w_wr_last) begin
              r_wr_cnt <= '0;
              r_state  <= (r_state == S_WR_L1) ? S_RD_L1 : S_RD_L2;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end

        S_RD_L1: begin
          if (bus.rd_ready) begin
            r_enb       <= 1'b1;
            r_addrb     <= w_rd_addr_l1;
            r_iss_conv2 <= 1'b1;
            r_iss_last  <= w_win_last;
            // kernel column fastest, then kernel row, then output x, then y
            if (r_kc == KW'(K - 1)) begin
              r_kc <= '0;
              if (r_kr == KW'(K - 1)) begin
                r_kr <= '0;
                if (r_ox == PW'(OX_N - 1)) begin
                  r_ox <= '0;
                  r_oy <= (r_oy == PW'(OY_N - 1)) ? '0 : r_oy + 1'b1;
                end else begin
                  r_ox <= r_ox + 1'b1;
                end
              end else begin
                r_kr <= r_kr + 1'b1;
              end
            end else begin
              r_kc <= r_kc + 1'b1;
            end
            if (w_rd_last) begin
              r_rd_cnt <= '0;
              r_state  <= S_WR_L2;
            end else begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end
        end

        S_RD_L2: begin
          if (bus.rd_ready) begin
            r_enb     <= 1'b1;
            r_addrb   <= w_rd_addr_l2;
            r_iss_fc1 <= 1'b1;
            if (w_rd_last) begin
              r_rd_cnt <= '0;
              r_state  <= S_DONE;
              r_done   <= 1'b1;
            end else begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ena            = r_ena;
  assign bus.wea            = r_wea;
  assign bus.addra          = r_addra;
  assign bus.dina           = r_dina;
  assign bus.enb            = r_enb;
  assign bus.addrb          = r_addrb;
  assign bus.conv2_i_valid  = r_conv2_valid;
  assign bus.conv2_win_last = r_conv2_last;
  assign bus.fc1_i_valid    = r_fc1_valid;
  assign o_done             = r_done;
  assign o_err              = r_err;

endmodule
